// File: rtl/c20_bist_pkg.sv
// c20_bist_pkg
// Shared types and constants for the C20 BIST controller slice.
//   state_t       : controller state encoding (IDLE, RUN, DONE)
//   PAT_W         : pattern / signature width
//   TAP_MASK      : x^16+x^14+x^13+x^11+1 taps (q[15], q[13], q[12], q[10])
//   DEFAULT_SEED  : power-on LFSR seed
//   eff_seed()    : maps an all-zero seed to 16'h0001 (the LFSR would lock up at 0)
package c20_bist_pkg;

  localparam int PAT_W = 16;

  localparam logic [PAT_W-1:0] TAP_MASK     = 16'hB400;
  localparam logic [PAT_W-1:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [PAT_W-1:0] eff_seed(input logic [PAT_W-1:0] seed);
    return (seed == '0) ? 16'h0001 : seed;
  endfunction

endpackage

// File: rtl/c20_bist_lfsr.sv
// c20_bist_lfsr
// 16-bit Fibonacci shift register with a serial injection input. Used both as
// the pattern generator (sin tied 0) and as the serial MISR (sin = response).
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset, loads RST_VAL
//   load      in   synchronous load of load_val (wins over en)
//   load_val  in   value loaded when load=1
//   en        in   shift one step: q <= {q[14:0], ^(q & TAPS) ^ sin}
//   sin       in   serial input xored into the feedback bit
//   q         out  register contents
module c20_bist_lfsr
  import c20_bist_pkg::*;
#(
  parameter logic [PAT_W-1:0] TAPS    = TAP_MASK,
  parameter logic [PAT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [PAT_W-1:0] load_val,
  input  logic             en,
  input  logic             sin,
  output logic [PAT_W-1:0] q
);

  logic fb;

  assign fb = (^(q & TAPS)) ^ sin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= {q[PAT_W-2:0], fb};
    end
  end

endmodule

// File: rtl/c20_bist_ctrl.sv
// c20_bist_ctrl
// BIST driver for the C20 benchmark: LFSR pattern source for G1gat..G16gat,
// serial MISR on the G17gat response, golden-signature compare.
// Optional feature macro: C20_BIST_ABORT_EN (adds abort_i; abort in RUN
// returns to IDLE with the partial signature held and no DONE).
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start_i      in   run request, level-sampled in IDLE/DONE
//   resp_i       in   DUT response, combinational from pat_o
//   abort_i      in   (C20_BIST_ABORT_EN only) abandon the current run
//   pat_o        out  live pattern in RUN, else 0
//   pat_valid_o  out  state == RUN
//   busy_o       out  state == RUN
//   done_o       out  state == DONE
//   pass_o       out  done_o && signature_o == GOLDEN_SIG
//   signature_o  out  MISR contents
//
// state | meaning
// IDLE  | waiting for start_i after reset or abort
// RUN   | one pattern per cycle, response compacted at each edge
// DONE  | run complete, signature final, waiting for start_i
module c20_bist_ctrl
  import c20_bist_pkg::*;
#(
  parameter int               N_PAT      = 256,
  parameter logic [PAT_W-1:0] SEED       = DEFAULT_SEED,
  parameter logic [PAT_W-1:0] GOLDEN_SIG = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             resp_i,
`ifdef C20_BIST_ABORT_EN
  input  logic             abort_i,
`endif
  output logic [PAT_W-1:0] pat_o,
  output logic             pat_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [PAT_W-1:0] signature_o
);

  localparam int               CNT_W    = $clog2(N_PAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_PAT - 1);
  localparam logic [PAT_W-1:0] EFF_SEED = eff_seed(SEED);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             start_run;
  logic             run_step;
  logic             abort_hit;
  logic             in_run;
  logic [PAT_W-1:0] gen_q;
  logic [PAT_W-1:0] sig_q;

  assign in_run = (state_q == RUN);

`ifdef C20_BIST_ABORT_EN
  assign abort_hit = in_run && abort_i;
`else
  assign abort_hit = 1'b0;
`endif

  // An aborted cycle does not count as a pattern: generator, MISR and
  // counter all hold so the partial signature stays observable.
  assign run_step = in_run && !abort_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    start_run = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          start_run = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (abort_hit) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (start_i) begin
          start_run = 1'b1;
          state_d   = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Counter width holds N_PAT itself, so the final increment never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (start_run) begin
      cnt_q <= '0;
    end else if (run_step) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  c20_bist_lfsr #(
    .TAPS    (TAP_MASK),
    .RST_VAL (EFF_SEED)
  ) u_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_run),
    .load_val (EFF_SEED),
    .en       (run_step),
    .sin      (1'b0),
    .q        (gen_q)
  );

  c20_bist_lfsr #(
    .TAPS    (TAP_MASK),
    .RST_VAL ('0)
  ) u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_run),
    .load_val ('0),
    .en       (run_step),
    .sin      (resp_i),
    .q        (sig_q)
  );

  // pat_o comes straight from registers (generator gated by state), so the
  // external netlist gets a full period to produce resp_i.
  assign pat_o       = in_run ? gen_q : '0;
  assign pat_valid_o = in_run;
  assign busy_o      = in_run;
  assign done_o      = (state_q == DONE);
  assign pass_o      = done_o && (sig_q == GOLDEN_SIG);
  assign signature_o = sig_q;

endmodule

// File: tb/tb_c20_bist_ctrl.sv
module tb_c20_bist_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // dut_a: default parameters, response = parity of a random subset of pattern bits
  logic        start_a = 1'b0;
  logic [15:0] mask_a = 16'h0000;
  logic        resp_a;
  logic [15:0] pat_a, sig_a;
  logic        val_a, busy_a, done_a, pass_a;
`ifdef C20_BIST_ABORT_EN
  logic        abort_a = 1'b0;
`endif
  assign resp_a = ^(pat_a & mask_a);

  // dut_b: N_PAT=4, GOLDEN 0
  logic        start_b = 1'b0, resp_b = 1'b0;
  logic [15:0] pat_b, sig_b;
  logic        val_b, busy_b, done_b, pass_b;

  // dut_c: SEED=0, N_PAT=3, GOLDEN 0007
  logic        start_c = 1'b0, resp_c = 1'b1;
  logic [15:0] pat_c, sig_c;
  logic        val_c, busy_c, done_c, pass_c;

  // dut_d: N_PAT=1
  logic        start_d = 1'b0, resp_d = 1'b1;
  logic [15:0] pat_d, sig_d;
  logic        val_d, busy_d, done_d, pass_d;

  c20_bist_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .resp_i(resp_a),
`ifdef C20_BIST_ABORT_EN
    .abort_i(abort_a),
`endif
    .pat_o(pat_a), .pat_valid_o(val_a), .busy_o(busy_a), .done_o(done_a),
    .pass_o(pass_a), .signature_o(sig_a)
  );

  c20_bist_ctrl #(.N_PAT(4), .GOLDEN_SIG(16'h0000)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .resp_i(resp_b),
`ifdef C20_BIST_ABORT_EN
    .abort_i(1'b0),
`endif
    .pat_o(pat_b), .pat_valid_o(val_b), .busy_o(busy_b), .done_o(done_b),
    .pass_o(pass_b), .signature_o(sig_b)
  );

  c20_bist_ctrl #(.N_PAT(3), .SEED(16'h0000), .GOLDEN_SIG(16'h0007)) dut_c (
    .clk(clk), .rst_n(rst_n), .start_i(start_c), .resp_i(resp_c),
`ifdef C20_BIST_ABORT_EN
    .abort_i(1'b0),
`endif
    .pat_o(pat_c), .pat_valid_o(val_c), .busy_o(busy_c), .done_o(done_c),
    .pass_o(pass_c), .signature_o(sig_c)
  );

  c20_bist_ctrl #(.N_PAT(1)) dut_d (
    .clk(clk), .rst_n(rst_n), .start_i(start_d), .resp_i(resp_d),
`ifdef C20_BIST_ABORT_EN
    .abort_i(1'b0),
`endif
    .pat_o(pat_d), .pat_valid_o(val_d), .busy_o(busy_d), .done_o(done_d),
    .pass_o(pass_d), .signature_o(sig_d)
  );

  // Reference step: shift left, new bit = x16 polynomial feedback xor serial input.
  function automatic logic [15:0] nxt(input logic [15:0] v, input logic b);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10] ^ b};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] pm, sm;
    logic        rb;
    int          nvalid;
    logic [15:0] exp_b [4];
    exp_b[0] = 16'h0000; exp_b[1] = 16'h0001; exp_b[2] = 16'h0003; exp_b[3] = 16'h0007;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pat", pat_a, 16'h0);
    chk("rst_valid", {15'b0, val_a}, 16'h0);
    chk("rst_busy", {15'b0, busy_a}, 16'h0);
    chk("rst_done", {15'b0, done_a}, 16'h0);
    chk("rst_pass", {15'b0, pass_a}, 16'h0);
    chk("rst_sig", sig_a, 16'h0);
    rst_n = 1'b1;
    tick();

    // full default run with a random response function
    mask_a  = 16'($urandom());
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    pm = 16'hACE1; sm = 16'h0; nvalid = 0;
    for (int k = 0; k < 256; k++) begin
      if (k == 0) chk("first_pat", pat_a, 16'hACE1);
      if (k == 1) chk("second_pat", pat_a, 16'h59C3);
      chk("run_pat", pat_a, pm);
      chk("run_sig", sig_a, sm);
      chk("run_done", {15'b0, done_a}, 16'h0);
      nvalid += int'(val_a);
      rb = ^(pm & mask_a);
      sm = nxt(sm, rb);
      pm = nxt(pm, 1'b0);
      tick();
    end
    chk("a_done", {15'b0, done_a}, 16'h1);
    chk("a_valid_after", {15'b0, val_a}, 16'h0);
    chk("a_pat_after", pat_a, 16'h0);
    chk("a_sig_final", sig_a, sm);
    chk("a_pass", {15'b0, pass_a}, {15'b0, sm == 16'h0});
    chk("a_valid_count", 16'(nvalid), 16'd256);
    repeat (3) tick();
    chk("a_done_hold", {15'b0, done_a}, 16'h1);
    chk("a_sig_hold", sig_a, sm);

    // reset at pattern 100
    mask_a  = 16'($urandom());
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    pm = 16'hACE1;
    for (int k = 0; k < 100; k++) begin
      pm = nxt(pm, 1'b0);
      tick();
    end
    chk("p100_pat", pat_a, pm);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pat", pat_a, 16'h0);
    chk("async_busy", {15'b0, busy_a}, 16'h0);
    chk("async_done", {15'b0, done_a}, 16'h0);
    chk("async_sig", sig_a, 16'h0);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("post_rst_busy", {15'b0, busy_a}, 16'h0);
      chk("post_rst_done", {15'b0, done_a}, 16'h0);
      chk("post_rst_pat", pat_a, 16'h0);
    end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("restart_pat", pat_a, 16'hACE1);

`ifdef C20_BIST_ABORT_EN
    // abort at pattern 10
    mask_a = 16'($urandom());
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    pm = 16'hACE1; sm = 16'h0;
    for (int k = 0; k < 10; k++) begin
      rb = ^(pm & mask_a);
      sm = nxt(sm, rb);
      pm = nxt(pm, 1'b0);
      tick();
    end
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    chk("abort_busy", {15'b0, busy_a}, 16'h0);
    chk("abort_done", {15'b0, done_a}, 16'h0);
    chk("abort_sig", sig_a, sm);
    for (int k = 0; k < 300; k++) begin
      tick();
      chk("abort_no_done", {15'b0, done_a}, 16'h0);
    end
    chk("abort_sig_hold", sig_a, sm);
`endif

    // dut_b: N_PAT=4, resp 1, start held high (back-to-back)
    resp_b  = 1'b1;
    start_b = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("b_busy", {15'b0, busy_b}, 16'h1);
      chk("b_done_low", {15'b0, done_b}, 16'h0);
      chk("b_sig_step", sig_b, exp_b[k]);
      tick();
    end
    chk("b_done5", {15'b0, done_b}, 16'h1);
    chk("b_sig_f", sig_b, 16'h000F);
    chk("b_pass0", {15'b0, pass_b}, 16'h0);
    tick();
    chk("b2b_busy", {15'b0, busy_b}, 16'h1);
    chk("b2b_done", {15'b0, done_b}, 16'h0);
    chk("b2b_sig_clr", sig_b, 16'h0);
    chk("b2b_pat", pat_b, 16'hACE1);
    start_b = 1'b0;
    resp_b  = 1'b0;
    repeat (4) tick();
    chk("b_zero_done", {15'b0, done_b}, 16'h1);
    chk("b_zero_sig", sig_b, 16'h0);
    chk("b_zero_pass", {15'b0, pass_b}, 16'h1);
    repeat (3) tick();
    chk("b_done_held", {15'b0, done_b}, 16'h1);
    chk("b_pass_held", {15'b0, pass_b}, 16'h1);

    // dut_b: random per-cycle responses
    for (int r = 0; r < 4; r++) begin
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      pm = 16'hACE1; sm = 16'h0;
      for (int k = 0; k < 4; k++) begin
        chk("br_pat", pat_b, pm);
        rb = 1'($urandom_range(0, 1));
        resp_b = rb;
        sm = nxt(sm, rb);
        pm = nxt(pm, 1'b0);
        tick();
      end
      chk("br_done", {15'b0, done_b}, 16'h1);
      chk("br_sig", sig_b, sm);
      chk("br_pass", {15'b0, pass_b}, {15'b0, sm == 16'h0});
    end

    // dut_c: zero seed replaced by 0001, golden match
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    chk("c_pat0", pat_c, 16'h0001);
    tick();
    chk("c_pat1", pat_c, 16'h0002);
    tick();
    chk("c_pat2", pat_c, 16'h0004);
    tick();
    chk("c_done", {15'b0, done_c}, 16'h1);
    chk("c_sig", sig_c, 16'h0007);
    chk("c_pass", {15'b0, pass_c}, 16'h1);

    // dut_d: single-pattern run
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    chk("d_busy", {15'b0, busy_d}, 16'h1);
    chk("d_pat", pat_d, 16'hACE1);
    tick();
    chk("d_busy_off", {15'b0, busy_d}, 16'h0);
    chk("d_done", {15'b0, done_d}, 16'h1);
    chk("d_sig", sig_d, 16'h0001);
    chk("d_pass", {15'b0, pass_d}, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
